wb_arbiter: RTL and testbench



---
 rtl/riscv_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 45 ++++
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the integer write-back path.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    // One write-back request: used for ALU results, LSU responses and the
    // LSU result buffer alike.
    typedef struct packed {
        logic             valid;
        reg_addr_t        rd;
        logic [XLEN-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for outstanding loads. One bit per integer
// register; x0 can never be pending. A set and a clear of the same register
// in one cycle leaves the bit set, because the new load is still in flight.
module wb_scoreboard
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_valid_i,
    input  reg_addr_t   set_rd_i,
    input  logic        clr_valid_i,
    input  reg_addr_t   clr_rd_i,
    input  reg_addr_t   look_a_i,
    input  reg_addr_t   look_b_i,
    input  reg_addr_t   look_c_i,
    output logic        hit_a_o,
    output logic        hit_b_o,
    output logic        hit_c_o,
    output logic [31:0] pending_o
);

    logic [31:0] pending_q, pending_d;

    // Next pending vector: clear first so a same-cycle set overrides it.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        pending_d = pending_q;
        if (clr_valid_i) pending_d[clr_rd_i] = 1'b0;
        if (set_valid_i) pending_d[set_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Pending register; reset empties it so no instruction stalls after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign hit_a_o   = pending_q[look_a_i];
    assign hit_b_o   = pending_q[look_b_i];
    assign hit_c_o   = pending_q[look_c_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-side master: ALU results have priority on the single write
// port; load responses wait in a one-entry buffer. Tracks outstanding load
// destinations for decode hazard stalls and requests an ALU bubble when the
// buffer has been starved for too long.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_issue_valid,
    input  logic [4:0]      lsu_issue_rd,
    input  logic            lsu_resp_valid,
    output logic            lsu_resp_ready,
    input  logic [4:0]      lsu_resp_rd,
    input  logic [XLEN-1:0] lsu_resp_data,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    input  logic            dec_uses_rs2,
    output logic            hazard_stall,
    output logic            drain_req,
    output logic            we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data
);

    import riscv_pkg::*;

    // Counter only needs to reach STARVE_LIMIT; it saturates there.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    wb_req_t          buf_q, buf_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             drain_q, drain_d;

    logic        alu_wins;
    logic        commit;
    logic        accept;
    logic        hit_rs1, hit_rs2, hit_rd;
    logic [31:0] pending;

    // An ALU write to x0 is dropped and leaves the port free for the buffer.
    assign alu_wins       = alu_valid && (alu_rd != 5'd0);
    assign commit         = buf_q.valid && !alu_wins;
    assign lsu_resp_ready = !buf_q.valid;
    assign accept         = lsu_resp_valid && lsu_resp_ready;

    // Write port mux: ALU first, then the buffered load result.
    always_comb begin
        we      = 1'b0;
        rd_addr = '0;
        rd_data = '0;
        if (alu_wins) begin
            we      = 1'b1;
            rd_addr = alu_rd;
            rd_data = alu_data;
        end else if (buf_q.valid) begin
            we      = 1'b1;
            rd_addr = buf_q.rd;
            rd_data = buf_q.data;
        end
    end

    // Buffer and starvation next state. Commit and accept are exclusive
    // because ready is low whenever there is something to commit.
    always_comb begin
        buf_d = buf_q;
        if (commit) begin
            buf_d.valid = 1'b0;
        end else if (accept && (lsu_resp_rd != 5'd0)) begin
            buf_d.valid = 1'b1;
            buf_d.rd    = lsu_resp_rd;
            buf_d.data  = lsu_resp_data;
        end

        starve_d = starve_q;
        if (!buf_d.valid) begin
            starve_d = '0;
        end else if (buf_q.valid && alu_wins && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
        drain_d = (starve_d >= LIMIT);
    end

    // State registers; reset discards any buffered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            starve_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            starve_q <= starve_d;
            drain_q  <= drain_d;
        end
    end

    assign drain_req = drain_q;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (lsu_issue_valid),
        .set_rd_i    (lsu_issue_rd),
        .clr_valid_i (commit),
        .clr_rd_i    (buf_q.rd),
        .look_a_i    (dec_rs1),
        .look_b_i    (dec_rs2),
        .look_c_i    (dec_rd),
        .hit_a_o     (hit_rs1),
        .hit_b_o     (hit_rs2),
        .hit_c_o     (hit_rd),
        .pending_o   (pending)
    );

    // RAW on either source, or WAW on the destination, of a pending load.
    assign hazard_stall = hit_rs1 || (dec_uses_rs2 && hit_rs2) || hit_rd;

    // An ALU result must never target a register with a load in flight.
    a_no_alu_to_pending : assert property (
        @(posedge clk) disable iff (!rst_n) alu_wins |-> !pending[alu_rd]
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_issue_valid;
    logic [4:0]      lsu_issue_rd;
    logic            lsu_resp_valid;
    logic            lsu_resp_ready;
    logic [4:0]      lsu_resp_rd;
    logic [XLEN-1:0] lsu_resp_data;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_uses_rs2;
    logic            hazard_stall;
    logic            drain_req;
    logic            we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    // Reference model: set of registers with loads in flight, the one
    // waiting load result, and how many cycles it has been blocked.
    bit              m_pend [32];
    bit              m_full;
    logic [4:0]      m_brd;
    logic [XLEN-1:0] m_bdata;
    int              m_blocked;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .lsu_issue_valid (lsu_issue_valid),
        .lsu_issue_rd    (lsu_issue_rd),
        .lsu_resp_valid  (lsu_resp_valid),
        .lsu_resp_ready  (lsu_resp_ready),
        .lsu_resp_rd     (lsu_resp_rd),
        .lsu_resp_data   (lsu_resp_data),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .dec_rd          (dec_rd),
        .dec_uses_rs2    (dec_uses_rs2),
        .hazard_stall    (hazard_stall),
        .drain_req       (drain_req),
        .we              (we),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_issue_valid = 0; lsu_issue_rd = 0;
        lsu_resp_valid = 0; lsu_resp_rd = 0; lsu_resp_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_uses_rs2 = 0;
    endtask

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 0;
        m_full = 0; m_brd = 0; m_bdata = 0; m_blocked = 0;
    endtask

    function automatic bit busy(input logic [4:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    // Compare every output with what the model says for the current inputs.
    task automatic check_all(input string tag);
        bit              alu_writes;
        logic            e_we;
        logic [4:0]      e_addr;
        logic [XLEN-1:0] e_data;
        logic            e_stall;
        #1;
        alu_writes = alu_valid && alu_rd != 0;
        e_we   = alu_writes || m_full;
        e_addr = alu_writes ? alu_rd   : (m_full ? m_brd   : 5'd0);
        e_data = alu_writes ? alu_data : (m_full ? m_bdata : '0);
        e_stall = busy(dec_rs1) || (dec_uses_rs2 && busy(dec_rs2)) || busy(dec_rd);
        check({tag, ".we"},      32'(we),             32'(e_we));
        check({tag, ".rd_addr"}, 32'(rd_addr),        32'(e_addr));
        check({tag, ".rd_data"}, rd_data,             e_data);
        check({tag, ".ready"},   32'(lsu_resp_ready), 32'(!m_full));
        check({tag, ".stall"},   32'(hazard_stall),   32'(e_stall));
        check({tag, ".drain"},   32'(drain_req),      32'(m_blocked >= LIMIT));
    endtask

    // Advance one clock, updating the model from the inputs of this cycle.
    task automatic tick();
        bit alu_writes;
        bit was_full;
        alu_writes = alu_valid && alu_rd != 0;
        was_full   = m_full;
        if (was_full && !alu_writes) begin
            m_pend[m_brd] = 0;
            m_full = 0;
        end else if (!was_full && lsu_resp_valid && lsu_resp_rd != 0) begin
            m_full  = 1;
            m_brd   = lsu_resp_rd;
            m_bdata = lsu_resp_data;
        end
        if (lsu_issue_valid && lsu_issue_rd != 0) m_pend[lsu_issue_rd] = 1;
        if (!m_full)                       m_blocked = 0;
        else if (was_full && alu_writes)   m_blocked++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 0;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        // ALU write goes straight to the port in the same cycle.
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        check_all("alu_first");
        check("alu_first.addr_const", 32'(rd_addr), 32'd5);
        tick();

        // Load to x7: RAW stall, then one-cycle response write, then release.
        idle();
        lsu_issue_valid = 1; lsu_issue_rd = 7;
        check_all("issue7");
        tick();
        idle();
        dec_rs1 = 7;
        lsu_resp_valid = 1; lsu_resp_rd = 7; lsu_resp_data = 32'hDEAD;
        check_all("resp7");
        check("resp7.stall_const", 32'(hazard_stall), 32'd1);
        tick();
        idle();
        dec_rs1 = 7;
        check_all("commit7");
        check("commit7.data_const", rd_data, 32'hDEAD);
        tick();
        idle();
        dec_rs1 = 7;
        check_all("after7");
        check("after7.stall_const", 32'(hazard_stall), 32'd0);

        // Starvation: ALU holds the port until drain_req, then bubbles.
        lsu_issue_valid = 1; lsu_issue_rd = 3;
        tick();
        idle();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hA0;
        lsu_resp_valid = 1; lsu_resp_rd = 3; lsu_resp_data = 32'h3333;
        check_all("starve_accept");
        tick();
        lsu_resp_valid = 0;
        for (int i = 0; i < 8 && m_full; i++) begin
            alu_valid = (m_blocked < LIMIT);
            alu_data  = 32'hA1 + i;
            check_all($sformatf("starve%0d", i));
            tick();
        end
        idle();
        check_all("starve_done");
        check("starve_done.drain_const", 32'(drain_req), 32'd0);

        // Same-cycle issue and commit of x9: the new load keeps it pending.
        lsu_issue_valid = 1; lsu_issue_rd = 9;
        tick();
        idle();
        lsu_resp_valid = 1; lsu_resp_rd = 9; lsu_resp_data = 32'h9999;
        tick();
        idle();
        lsu_issue_valid = 1; lsu_issue_rd = 9;
        check_all("reissue9");
        tick();
        idle();
        dec_rd = 9;
        check_all("waw9");
        check("waw9.stall_const", 32'(hazard_stall), 32'd1);

        // ALU write to x0 lets the buffer drain; response to x0 is dropped.
        idle();
        lsu_resp_valid = 1; lsu_resp_rd = 4; lsu_resp_data = 32'h4444;
        tick();
        idle();
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        check_all("x0_alu");
        check("x0_alu.addr_const", 32'(rd_addr), 32'd4);
        tick();
        idle();
        lsu_resp_valid = 1; lsu_resp_rd = 0; lsu_resp_data = 32'hBAD0;
        check_all("x0_resp");
        tick();
        idle();
        check_all("x0_after");
        check("x0_after.we_const", 32'(we), 32'd0);

        // Asynchronous reset with a full buffer and x12 pending.
        lsu_issue_valid = 1; lsu_issue_rd = 12;
        tick();
        idle();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
        lsu_resp_valid = 1; lsu_resp_rd = 3; lsu_resp_data = 32'h3030;
        tick();
        lsu_resp_valid = 0;
        dec_rs1 = 12;
        check_all("prerst");
        alu_valid = 0;
        rst_n = 0;
        model_reset();
        check_all("async_rst");
        check("async_rst.ready_const", 32'(lsu_resp_ready), 32'd1);
        rst_n = 1;
        idle();
        dec_rs1 = 12;
        tick();
        check_all("post_rst");

        // Random traffic; upstream obeys the WAW and drain rules.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] r;
            idle();
            r = 5'($urandom_range(0, 31));
            alu_valid = (m_blocked < LIMIT) && ($urandom_range(0, 3) != 0);
            alu_rd    = m_pend[r] ? 5'd0 : r;
            alu_data  = $urandom;
            lsu_issue_valid = ($urandom_range(0, 2) == 0);
            lsu_issue_rd    = 5'($urandom_range(0, 31));
            lsu_resp_valid  = $urandom_range(0, 1) == 1;
            lsu_resp_rd     = 5'($urandom_range(0, 31));
            lsu_resp_data   = $urandom;
            dec_rs1 = 5'($urandom_range(0, 31));
            dec_rs2 = 5'($urandom_range(0, 31));
            dec_rd  = 5'($urandom_range(0, 31));
            dec_uses_rs2 = $urandom_range(0, 1) == 1;
            check_all("rnd");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
